// File: rtl/even_count_pkg.sv
// Shared types, default sizing and successor arithmetic for the even-step
// counter stream checker.
package even_count_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_STEP  = 2;
  localparam int GOOD_W    = 3;

  // Successor of cur, wrapped to a width-bit bus.
  function automatic logic [31:0] next_value(input logic [31:0] cur,
                                             input int unsigned step,
                                             input int unsigned width);
    logic [31:0] mask;
    if (width >= 32) begin
      mask = '1;
    end else begin
      mask = (32'd1 << width) - 32'd1;
    end
    return (cur + step) & mask;
  endfunction

endpackage

// File: rtl/even_count_checker_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones.
module sat_counter #(
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [ERR_W-1:0] count
);

  logic [ERR_W-1:0] count_q;
  logic [ERR_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {ERR_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/even_count_checker.sv
// Receive-side monitor for the even-step counter stream: acquires lock on the
// wrapping sequence, then pulses and counts every out-of-sequence sample.
module even_count_checker
  import even_count_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int STEP     = DEF_STEP,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expect_data
);

  localparam logic [WIDTH-1:0]  LOW_MASK = WIDTH'(STEP - 1);
  localparam logic [GOOD_W-1:0] LOCK_N   = GOOD_W'(LOCK_CNT);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   ref_q, ref_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic               miss_q, miss_d;
  logic               err_q, err_d;
  logic               locked_q, locked_d;
  logic [WIDTH-1:0]   expect_q, expect_d;
  logic [WIDTH-1:0]   pred;
  logic               legal;
  logic               match;

  always_comb begin
    pred  = WIDTH'(next_value(32'(ref_q), STEP, WIDTH));
    legal = ((in_data & LOW_MASK) == '0);
    match = legal && (in_data == pred);

    state_d = state_q;
    ref_d   = ref_q;
    good_d  = good_q;
    miss_d  = miss_q;
    err_d   = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (legal) begin
            ref_d   = in_data;
            good_d  = '0;
            state_d = SYNC;
          end
        end
        SYNC: begin
          if (match) begin
            ref_d  = in_data;
            good_d = good_q + 1'b1;
            if (good_q + 1'b1 == LOCK_N) begin
              state_d = LOCKED;
            end
          end else if (legal) begin
            // Restart the run from this sample rather than dropping to HUNT.
            ref_d  = in_data;
            good_d = '0;
          end else begin
            state_d = HUNT;
            ref_d   = '0;
            good_d  = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            ref_d  = in_data;
            miss_d = 1'b0;
          end else begin
            err_d = 1'b1;
            if (miss_q) begin
              state_d = HUNT;
              ref_d   = '0;
              good_d  = '0;
              miss_d  = 1'b0;
            end else begin
              // Flywheel over a single bad sample; its value is never trusted.
              ref_d  = pred;
              miss_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = HUNT;
          ref_d   = '0;
          good_d  = '0;
          miss_d  = 1'b0;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
    if (state_d == HUNT) begin
      expect_d = '0;
    end else begin
      expect_d = WIDTH'(next_value(32'(ref_d), STEP, WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= HUNT;
      ref_q    <= '0;
      good_q   <= '0;
      miss_q   <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
      expect_q <= '0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      good_q   <= good_d;
      miss_q   <= miss_d;
      err_q    <= err_d;
      locked_q <= locked_d;
      expect_q <= expect_d;
    end
  end

  sat_counter #(
    .ERR_W(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (err_d),
    .count(err_count)
  );

  assign locked      = locked_q;
  assign err         = err_q;
  assign expect_data = expect_q;

endmodule

// File: tb/tb_even_count_checker.sv
// Directed-vector bench for even_count_checker with hand-computed expectations.
module tb_even_count_checker;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_data;
  logic       locked;
  logic       err;
  logic [3:0] err_count;
  logic [2:0] expect_data;

  int n_cmp;
  int n_bad;

  even_count_checker #(
    .WIDTH(3), .STEP(2), .LOCK_CNT(2), .ERR_W(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .locked     (locked),
    .err        (err),
    .err_count  (err_count),
    .expect_data(expect_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
    end
  endtask

  // Present one input for one cycle; return #1 after the sampling edge.
  task automatic drive(input logic r, input logic v, input logic [2:0] d);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic l, input logic e,
                            input logic [3:0] c, input logic [2:0] x);
    check_val({tag, ".locked"}, 32'(locked), 32'(l));
    check_val({tag, ".err"}, 32'(err), 32'(e));
    check_val({tag, ".err_count"}, 32'(err_count), 32'(c));
    check_val({tag, ".expect"}, 32'(expect_data), 32'(x));
  endtask

  initial begin
    int cnt;
    int mref;
    logic [2:0] gap_data [5];
    gap_data = '{3'd5, 3'd7, 3'd1, 3'd3, 3'd6};
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;

    drive(1'b0, 1'b0, 3'd0);
    expect_all("reset", 0, 0, 0, 0);

    // Acquire, lock after the sample 4, wrap 6 -> 0 silently.
    drive(1'b1, 1'b1, 3'd0); expect_all("acq0", 0, 0, 0, 2);
    drive(1'b1, 1'b1, 3'd2); expect_all("acq2", 0, 0, 0, 4);
    drive(1'b1, 1'b1, 3'd4); expect_all("acq4", 1, 0, 0, 6);
    drive(1'b1, 1'b1, 3'd6); expect_all("acq6", 1, 0, 0, 0);
    drive(1'b1, 1'b1, 3'd0); expect_all("wrap0", 1, 0, 0, 2);
    drive(1'b1, 1'b1, 3'd2); expect_all("acq2b", 1, 0, 0, 4);

    // Single bad sample is flywheeled over.
    drive(1'b1, 1'b1, 3'd4); expect_all("one4", 1, 0, 0, 6);
    drive(1'b1, 1'b1, 3'd0); expect_all("onebad", 1, 1, 1, 0);
    drive(1'b1, 1'b1, 3'd0); expect_all("oneresume", 1, 0, 1, 2);

    // Two consecutive bad samples drop lock.
    drive(1'b1, 1'b1, 3'd2); expect_all("two2", 1, 0, 1, 4);
    drive(1'b1, 1'b1, 3'd4); expect_all("two4", 1, 0, 1, 6);
    drive(1'b1, 1'b1, 3'd4); expect_all("twobad1", 1, 1, 2, 0);
    drive(1'b1, 1'b1, 3'd4); expect_all("twobad2", 0, 1, 3, 0);

    // Odd sample: ignored in HUNT, an error when LOCKED.
    drive(1'b1, 1'b1, 3'd3); expect_all("hunt_odd", 0, 0, 3, 0);
    drive(1'b1, 1'b1, 3'd0); expect_all("re0", 0, 0, 3, 2);
    drive(1'b1, 1'b1, 3'd2); expect_all("re2", 0, 0, 3, 4);
    drive(1'b1, 1'b1, 3'd4); expect_all("re4", 1, 0, 3, 6);
    drive(1'b1, 1'b1, 3'd3); expect_all("lock_odd", 1, 1, 4, 0);
    drive(1'b1, 1'b1, 3'd0); expect_all("odd_resume", 1, 0, 4, 2);

    // Gap with garbage on the bus: everything frozen.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, gap_data[i]);
      expect_all($sformatf("gap%0d", i), 1, 0, 4, 2);
    end
    drive(1'b1, 1'b1, 3'd2); expect_all("gap_resume", 1, 0, 4, 4);

    // Alternate bad/good samples to drive err_count into saturation.
    cnt  = 4;
    mref = 2;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, 3'd7);
      mref = (mref + 2) % 8;
      cnt  = (cnt < 15) ? cnt + 1 : 15;
      expect_all($sformatf("sat_bad%0d", i), 1, 1, 4'(cnt), 3'((mref + 2) % 8));
      mref = (mref + 2) % 8;
      drive(1'b1, 1'b1, 3'(mref));
      expect_all($sformatf("sat_good%0d", i), 1, 0, 4'(cnt), 3'((mref + 2) % 8));
    end
    check_val("sat_final", 32'(err_count), 32'd15);

    // Reset mid-stream while a valid, correct sample is presented.
    drive(1'b0, 1'b1, 3'((mref + 2) % 8)); expect_all("mid_rst", 0, 0, 0, 0);
    drive(1'b1, 1'b1, 3'd0); expect_all("post0", 0, 0, 0, 2);
    drive(1'b1, 1'b1, 3'd2); expect_all("post2", 0, 0, 0, 4);
    drive(1'b1, 1'b1, 3'd4); expect_all("post4", 1, 0, 0, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
